blink_delay_ctrl: RTL and testbench

//   Multi-channel successor of the single blinker delay register. Holds one delay per blinker channel.

---
 rtl/blink_pkg.sv | 18 +
 rtl/blink_delay_ctrl_if.sv | 14 +
 rtl/blink_delay_chan.sv | 104 ++++++++++
 rtl/blink_delay_ctrl.sv | 82 ++++++++
 tb/tb_blink_delay_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared constants and types for the multi-channel blinker delay controller.
package blink_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LOCK_ADDR = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } chan_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blink_delay_ctrl_if.sv
// Avalon-MM register port between the HPS lightweight bridge and the delay controller.
interface blink_delay_ctrl_if;
    import blink_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic [DATA_W-1:0] readdata;

    modport master (output address, write, writedata, read, input readdata);
    modport slave  (input address, write, writedata, read, output readdata);

endinterface

// File: rtl/blink_delay_chan.sv
// One delay channel: press/hold/auto-repeat FSM driving a saturating delay register.
module blink_delay_chan
    import blink_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned MIN_DELAY     = 1,
    parameter int unsigned MAX_DELAY     = 15,
    parameter int unsigned RESET_DELAY   = 8,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             faster,
    input  logic             slower,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] delay
);

    localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_DELAY);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_DELAY);
    localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_DELAY);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    chan_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             rearm_wait;
    logic             req;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] wr_clamped;

    assign req = faster ^ slower;

    // Saturating one-step neighbour of the current delay and clamped bus value.
    always_comb begin
        stepped    = delay;
        wr_clamped = wr_data;
        if (faster) begin
            stepped = (delay <= MIN_V) ? MIN_V : WIDTH'(delay - 1'b1);
        end else begin
            stepped = (delay >= MAX_V) ? MAX_V : WIDTH'(delay + 1'b1);
        end
        if (wr_data < MIN_V) begin
            wr_clamped = MIN_V;
        end else if (wr_data > MAX_V) begin
            wr_clamped = MAX_V;
        end
    end

    // A bus write freezes the FSM for that cycle; after reset a held button must be released first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            delay      <= RESET_V;
            rearm_wait <= 1'b1;
        end else begin
            if (!req) begin
                rearm_wait <= 1'b0;
            end
            if (wr_en) begin
                delay <= wr_clamped;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req && !rearm_wait) begin
                            delay <= stepped;
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!req) begin
                            state <= ST_IDLE;
                        end else if (cnt == HOLD_LAST) begin
                            delay <= stepped;
                            cnt   <= '0;
                            state <= ST_RPT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RPT: begin
                        if (!req) begin
                            state <= ST_IDLE;
                        end else if (cnt == RPT_LAST) begin
                            delay <= stepped;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/blink_delay_ctrl.sv
// Multi-channel blinker delay register bank with button stepping and an Avalon-MM slave.
module blink_delay_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned MIN_DELAY     = 1,
    parameter int unsigned MAX_DELAY     = 15,
    parameter int unsigned RESET_DELAY   = 8,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       faster,
    input  logic [CHANNELS-1:0]       slower,
    blink_delay_ctrl_if.slave         bus,
    output logic [CHANNELS*WIDTH-1:0] delay,
    output logic                      lock
);

    logic [CHANNELS-1:0] faster_m;
    logic [CHANNELS-1:0] slower_m;
    logic [CHANNELS-1:0] wr_sel;
    logic [DATA_W-1:0]   rd_mux;
    logic                lock_sel;
    logic                unused_wdata;

    assign faster_m     = lock ? '0 : faster;
    assign slower_m     = lock ? '0 : slower;
    assign lock_sel     = (bus.address == ADDR_W'(LOCK_ADDR));
    assign unused_wdata = ^bus.writedata[DATA_W-1:WIDTH];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign wr_sel[g] = bus.write && (bus.address == ADDR_W'(g));

        blink_delay_chan #(
            .WIDTH         (WIDTH),
            .MIN_DELAY     (MIN_DELAY),
            .MAX_DELAY     (MAX_DELAY),
            .RESET_DELAY   (RESET_DELAY),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .faster  (faster_m[g]),
            .slower  (slower_m[g]),
            .wr_en   (wr_sel[g]),
            .wr_data (bus.writedata[WIDTH-1:0]),
            .delay   (delay[g*WIDTH +: WIDTH])
        );
    end

    // Read decode; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            if (bus.address == ADDR_W'(n)) begin
                rd_mux = DATA_W'(delay[n*WIDTH +: WIDTH]);
            end
        end
        if (lock_sel) begin
            rd_mux = DATA_W'(lock);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock         <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (bus.write && lock_sel) begin
                lock <= bus.writedata[0];
            end
            if (bus.read) begin
                bus.readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_blink_delay_ctrl.sv
// Directed scoreboard bench for blink_delay_ctrl with shortened hold/repeat timing.
module tb_blink_delay_ctrl;
    import blink_pkg::*;

    localparam int unsigned CH = 4;
    localparam int unsigned W  = 4;

    typedef struct {
        string       tag;
        int          kind;   // 0 readdata, 1 delay vector, 2 lock
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] faster;
    logic [CH-1:0] slower;
    logic [CH*W-1:0] delay;
    logic          lock;

    blink_delay_ctrl_if bus();

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    blink_delay_ctrl #(
        .CHANNELS(CH), .WIDTH(W), .MIN_DELAY(1), .MAX_DELAY(15), .RESET_DELAY(8),
        .HOLD_CYCLES(8), .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .faster(faster), .slower(slower),
        .bus(bus), .delay(delay), .lock(lock)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = kind; e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = bus.readdata;
                1:       obs = 32'(delay);
                default: obs = 32'(lock);
            endcase
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [4:0] a, input logic [31:0] v);
        bus.address = a; bus.read = 1'b1;
        expect_val(tag, 0, v);
        tick();
        bus.read = 1'b0;
        check_all();
    endtask

    initial begin
        int steps;
        logic [3:0] lane;
        reset_n = 1'b0; faster = '0; slower = '0;
        bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        expect_val("reset_delay", 1, 32'h8888);
        expect_val("reset_lock", 2, 32'h0);
        expect_val("reset_readdata", 0, 32'h0);
        check_all();
        tick();

        // 1: read channel 2, then readdata must hold with read low
        bus_read("read_ch2", 5'd2, 32'd8);
        bus.address = 5'd0;
        tick();
        expect_val("readdata_hold", 0, 32'd8);
        check_all();

        // 2: single faster pulse on channel 0
        faster = 4'b0001; tick(); faster = '0;
        expect_val("pulse_faster0", 1, 32'h8887);
        check_all();
        tick(); tick();
        expect_val("pulse_faster0_stable", 1, 32'h8887);
        check_all();

        // 3: hold slower[1] for 30 edges: steps at 0, 8, 12, ... saturating at 15
        slower = 4'b0010;
        steps = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 0 || (k >= 8 && (k - 8) % 4 == 0)) steps++;
            lane = (8 + steps > 15) ? 4'd15 : 4'(8 + steps);
            tick();
            expect_val($sformatf("hold_slower1_e%0d", k), 1, {16'h0, 8'h88, lane, 4'h7});
            check_all();
        end
        slower = '0; tick(); tick();
        expect_val("release_slower1", 1, 32'h88F7);
        check_all();

        // 4: clamped writes and write-vs-step priority on channel 3
        bus_write(5'd3, 32'h0);
        expect_val("write_clamp_min", 1, 32'h18F7);
        check_all();
        bus_write(5'd3, 32'hFF);
        expect_val("write_clamp_max", 1, 32'hF8F7);
        check_all();
        faster = 4'b1000;
        bus_write(5'd3, 32'h5);
        faster = '0;
        expect_val("write_beats_step", 1, 32'h58F7);
        check_all();
        tick();
        expect_val("write_beats_step_after", 1, 32'h58F7);
        check_all();
        bus_read("read_ch3", 5'd3, 32'd5);
        bus_read("read_unmapped", 5'd20, 32'd0);

        // 5: lock masks buttons; unlock restores them
        bus_write(5'd16, 32'hFFFF_FFFF);
        expect_val("lock_set", 2, 32'h1);
        check_all();
        bus_read("read_lock", 5'd16, 32'h1);
        faster = 4'b1111; tick(); faster = '0; tick();
        expect_val("locked_no_change", 1, 32'h58F7);
        check_all();
        bus_write(5'd16, 32'h0);
        bus_read("read_unlock", 5'd16, 32'h0);
        faster = 4'b0100; tick(); faster = '0;
        expect_val("unlocked_faster2", 1, 32'h57F7);
        check_all();

        // 6: reset while holding in RPT, then rearm only on a fresh press
        faster = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        expect_val("hold_faster0_rpt", 1, 32'h57F5);
        check_all();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        expect_val("reset_mid_hold", 1, 32'h8888);
        check_all();
        for (int k = 0; k < 15; k++) tick();
        expect_val("held_after_reset", 1, 32'h8888);
        check_all();
        faster = '0; tick();
        faster = 4'b0001; tick();
        expect_val("repress_after_reset", 1, 32'h8887);
        check_all();
        faster = '0; tick();
        faster = 4'b0001; slower = 4'b0001;
        for (int k = 0; k < 10; k++) tick();
        expect_val("both_pressed", 1, 32'h8887);
        check_all();
        faster = '0; slower = 4'b0001; tick();
        expect_val("dir_change_slower0", 1, 32'h8888);
        check_all();
        slower = '0; tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
